mem_dump_tx: RTL and testbench
==============================

MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit period (legal range 1..65535).
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-005 base_addr  input  32  first word address, latched on an accepted start.
REQ-006 word_count  input  16  number of 32-bit words to send, latched on an accepted start.
REQ-007 mem_addr  output  32  word address presented to the data memory.
REQ-008 mem_oe  output  1  memory output enable, high only in FETCH.
REQ-009 mem_data  input  32  memory read data; valid by the end of the cycle in which mem_oe is high.
REQ-010 tx  output  1  serial line, 8N1 framing, idle high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when a dump completes or a zero-length start is accepted.

Function
REQ-013 States: IDLE, FETCH, START, DATA, STOP; no other encodings are reachable.
REQ-014 IDLE: tx=1, mem_oe=0, busy=0; start=1 with word_count!=0 -> latch inputs, mem_addr<=base_addr, go FETCH.
REQ-015 IDLE, start=1 with word_count==0 -> done=1 on the next cycle, remain IDLE, mem_oe never asserted.
REQ-016 FETCH lasts exactly 1 cycle with mem_oe=1: capture mem_data into a 32-bit word register at the closing edge, byte_idx<=0, go START.
REQ-017 Bytes go out LSB byte first (word[7:0] first, word[31:24] last); bits within a byte go out LSB first.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles; DATA: 8 bits at CLKS_PER_BIT cycles each; STOP: tx=1 for CLKS_PER_BIT cycles.
REQ-019 End of STOP with byte_idx<3 -> byte_idx+1, go START (no idle gap between bytes).
REQ-020 End of STOP with byte_idx==3 -> decrement the remaining count; if zero go IDLE with done=1 for the next cycle; otherwise mem_addr<=mem_addr+1, go FETCH.
REQ-021 Cycles per word = 1 + 40*CLKS_PER_BIT; total dump = word_count*(1+40*CLKS_PER_BIT) cycles from the first FETCH cycle to the done pulse.
REQ-022 mem_addr increments modulo 2^32 (0xFFFFFFFF wraps to 0x00000000); it holds its value outside FETCH transitions.
REQ-023 start while busy is ignored; latched parameters are not altered; no queued request is kept.
REQ-024 word_count==65535 is legal and sends 65535 words; the remaining counter never underflows.
REQ-025 tx is driven from a register (glitch-free); the bit-period counter restarts at every bit boundary.
REQ-026 done and start in the same cycle in IDLE: done is emitted and the new start is accepted.

Reset
REQ-027 On reset=1 at a posedge: state=IDLE, tx=1, mem_oe=0, busy=0, done=0, mem_addr=0, all counters and the word register = 0.
REQ-028 Reset mid-dump aborts immediately: tx returns high on the same edge, no done pulse, partial frame discarded.
REQ-029 Reset dominates start in the same cycle.

Verification
REQ-030 CPB=4, base=0x10, count=1, mem[0x10]=0xA55A0FF0 -> one FETCH at addr 0x10; tx bytes 0xF0,0x0F,0x5A,0xA5 framed 0/data/1; done exactly 161 cycles after the FETCH cycle begins.
REQ-031 count=3, base=0xFFFFFFFF -> FETCH addresses 0xFFFFFFFF, 0x00000000, 0x00000001 in order; done after 3*161 cycles; busy high throughout.
REQ-032 start with count=0 -> done pulse next cycle; busy stays 0; mem_oe stays 0; tx stays 1.
REQ-033 start pulsed during the second byte of a 2-word dump -> ignored; exactly 8 bytes sent; a single done pulse.
REQ-034 reset asserted during the DATA bit 3 of byte 1 -> next cycle tx=1, busy=0, mem_addr=0; a following start with base=0x20, count=1 dumps correctly.
REQ-035 CPB=1 and count=2 -> every bit lasts 1 cycle, and there are no gap cycles between bytes; a 1-cycle FETCH occurs between words.

Source files
------------

// File: rtl/mem_dump_tx.sv
// Memory dump transmitter: reads a block of 32-bit words from a data memory
// and sends each word as four 8N1 serial frames, low byte first.
module mem_dump_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    output logic [31:0] mem_addr,
    output logic        mem_oe,
    input  logic [31:0] mem_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    // Bit period counter runs 0..LAST_CLK, so each bit lasts CLKS_PER_BIT cycles.
    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  state;
    logic [15:0] remaining;
    logic [31:0] word_reg;
    logic [1:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [15:0] clk_cnt;
    logic [7:0]  cur_byte;
    logic [2:0]  next_bit;
    logic        bit_end;

    assign mem_oe   = (state == FETCH);
    assign busy     = (state != IDLE);
    assign bit_end  = (clk_cnt == LAST_CLK);
    assign next_bit = bit_idx + 3'd1;

    // Select the byte of the captured word currently being framed.
    always_comb begin
        cur_byte = word_reg[7:0];
        case (byte_idx)
            2'd0:    cur_byte = word_reg[7:0];
            2'd1:    cur_byte = word_reg[15:8];
            2'd2:    cur_byte = word_reg[23:16];
            default: cur_byte = word_reg[31:24];
        endcase
    end

    // Dump sequencer; tx is registered and updated one edge ahead of each bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            done      <= 1'b0;
            mem_addr  <= 32'd0;
            remaining <= 16'd0;
            word_reg  <= 32'd0;
            byte_idx  <= 2'd0;
            bit_idx   <= 3'd0;
            clk_cnt   <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    clk_cnt <= 16'd0;
                    if (start) begin
                        if (word_count == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= word_count;
                            mem_addr  <= base_addr;
                            state     <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    word_reg <= mem_data;
                    byte_idx <= 2'd0;
                    bit_idx  <= 3'd0;
                    clk_cnt  <= 16'd0;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= 16'd0;
                        bit_idx <= 3'd0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= next_bit;
                            tx      <= cur_byte[next_bit];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= 16'd0;
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                mem_addr <= mem_addr + 32'd1;
                                state    <= FETCH;
                            end
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Self-checking bench for mem_dump_tx: two instances (CLKS_PER_BIT 4 and 1)
// compared cycle by cycle against a waveform computed from the framing rules.
module tb_mem_dump_tx;

    logic        clock = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic [31:0] mem_addr0, mem_addr1, mem_data0, mem_data1;
    logic        mem_oe0, mem_oe1, tx0, tx1, busy0, busy1, done0, done1;
    logic [31:0] salt = 32'h1234_5678;
    int          checks = 0;
    int          failures = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Pseudo-random memory contents, with the fixed word at 0x10.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hA55A0FF0;
        return (a * 32'h9E3779B1) ^ salt ^ {a[15:0], a[31:16]};
    endfunction

    assign mem_data0 = mem_word(mem_addr0);
    assign mem_data1 = mem_word(mem_addr1);

    mem_dump_tx #(.CLKS_PER_BIT(4)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .base_addr(base_addr),
        .word_count(word_count), .mem_addr(mem_addr0), .mem_oe(mem_oe0),
        .mem_data(mem_data0), .tx(tx0), .busy(busy0), .done(done0)
    );

    mem_dump_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .base_addr(base_addr),
        .word_count(word_count), .mem_addr(mem_addr1), .mem_oe(mem_oe1),
        .mem_data(mem_data1), .tx(tx1), .busy(busy1), .done(done1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Observed {tx, mem_oe, busy, done} of the selected instance.
    function automatic logic [31:0] obs(input bit sel);
        if (sel) return {28'd0, tx1, mem_oe1, busy1, done1};
        return {28'd0, tx0, mem_oe0, busy0, done0};
    endfunction

    function automatic logic [31:0] obs_addr(input bit sel);
        return sel ? mem_addr1 : mem_addr0;
    endfunction

    // Reference: {tx, mem_oe, busy, done} expected k cycles after the start edge.
    function automatic logic [31:0] expect_vec(input int k, input int n, input int cpb,
                                               input logic [31:0] base);
        int          len;
        int          w, o, p, by, bp;
        logic [31:0] data;
        logic [7:0]  bval;
        logic        txv;
        len = 1 + 40 * cpb;
        if (k >= n * len) return (k == n * len) ? 32'b1001 : 32'b1000;
        w = k / len;
        o = k % len;
        if (o == 0) return 32'b1110;
        p  = o - 1;
        by = p / (10 * cpb);
        bp = (p % (10 * cpb)) / cpb;
        data = mem_word(base + 32'(w));
        bval = 8'(data >> (8 * by));
        if (bp == 0)      txv = 1'b0;
        else if (bp == 9) txv = 1'b1;
        else              txv = bval[bp-1];
        return {28'd0, txv, 1'b0, 1'b1, 1'b0};
    endfunction

    task automatic setStart(input bit sel, input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // Run one dump from the current negedge up to and including the done cycle.
    // inject_k >= 0 pulses a conflicting start while busy; abort_k >= 0 resets there.
    task automatic applyStimulus(input bit sel, input logic [31:0] base, input int n,
                                 input int inject_k, input int abort_k);
        int cpb, len, total;
        cpb   = sel ? 1 : 4;
        len   = 1 + 40 * cpb;
        total = n * len;
        base_addr  = base;
        word_count = 16'(n);
        setStart(sel, 1'b1);
        for (int k = 0; k <= total; k++) begin
            @(negedge clock);
            start0 = 1'b0;
            start1 = 1'b0;
            reset  = 1'b0;
            checkOutput($sformatf("dut%0d base %h k%0d", sel, base, k), obs(sel),
                        expect_vec(k, n, cpb, base));
            if (k < total && (k % len) == 0)
                checkOutput($sformatf("dut%0d fetch addr k%0d", sel, k), obs_addr(sel),
                            base + 32'(k / len));
            if (k == inject_k) begin
                setStart(sel, 1'b1);
                base_addr  = ~base;
                word_count = 16'd5;
            end
            if (k == abort_k) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                checkOutput("abort outputs", obs(sel), 32'b1000);
                checkOutput("abort mem_addr", obs_addr(sel), 32'd0);
                @(negedge clock);
                checkOutput("abort no done", obs(sel), 32'b1000);
                return;
            end
        end
    endtask

    task automatic idleCheck(input bit sel);
        @(negedge clock);
        checkOutput($sformatf("dut%0d idle after done", sel), obs(sel), 32'b1000);
    endtask

    initial begin
        reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        base_addr = 32'd0;
        word_count = 16'd0;
        salt = $urandom;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("reset dut0", obs(0), 32'b1000);
        checkOutput("reset dut1", obs(1), 32'b1000);
        checkOutput("reset addr0", mem_addr0, 32'd0);
        checkOutput("reset addr1", mem_addr1, 32'd0);

        // Single known word at 0x10
        applyStimulus(0, 32'h10, 1, -1, -1);
        idleCheck(0);

        // Address wrap over three words
        applyStimulus(0, 32'hFFFF_FFFF, 3, -1, -1);
        idleCheck(0);

        // Zero-length request
        word_count = 16'd0;
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        checkOutput("zero-length done", obs(0), 32'b1001);
        @(negedge clock);
        checkOutput("zero-length after", obs(0), 32'b1000);

        // Start pulsed during the second byte is ignored
        applyStimulus(0, $urandom, 2, 53, -1);
        idleCheck(0);

        // Back-to-back dumps: new start accepted in the done cycle
        applyStimulus(0, $urandom, 1, -1, -1);
        applyStimulus(0, $urandom, 1, -1, -1);
        idleCheck(0);

        // Reset during DATA bit 3 of byte 1, then a clean dump from 0x20
        applyStimulus(0, 32'h0000_0300, 1, -1, 57);
        applyStimulus(0, 32'h20, 1, -1, -1);
        idleCheck(0);

        // Reset dominates a simultaneous start
        base_addr = 32'h55;
        word_count = 16'd1;
        reset = 1'b1;
        start0 = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start0 = 1'b0;
        checkOutput("reset vs start", obs(0), 32'b1000);
        checkOutput("reset vs start addr", mem_addr0, 32'd0);
        @(negedge clock);
        checkOutput("reset vs start later", obs(0), 32'b1000);

        // One clock per bit, two words
        applyStimulus(1, $urandom, 2, -1, -1);
        idleCheck(1);

        // Random dumps on both instances
        for (int i = 0; i < 6; i++) begin
            bit sel;
            sel = 1'($urandom_range(0, 1));
            applyStimulus(sel, (i == 2) ? 32'hFFFF_FFFE : $urandom,
                          int'($urandom_range(1, 3)), -1, -1);
            idleCheck(sel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
